// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU write-back, word load/store on a local data memory, and beq resolution.
// Loads run IDLE -> RD_ADDR -> RD_DATA -> IDLE and hold off EX with ex_ready low while in flight.
module mem_wb_stage #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_cout,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_branch,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              wb_cout,
    output logic              branch_taken,
    output logic              fault
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_ADDR = 2'd1;
    localparam logic [1:0] ST_RD_DATA = 2'd2;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic              ld_rw_q, ld_rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_cout_q, wb_cout_d;
    logic              branch_taken_q, branch_taken_d;
    logic              fault_q, fault_d;

    logic              xfer;
    logic              bad_op;
    logic              mem_we;
    logic [ADDR_W-1:0] idx;

    assign ex_ready = (state_q == ST_IDLE);
    assign xfer     = ex_valid & ex_ready & enable;
    assign idx      = ex_result[ADDR_W+1:2];
    // Misaligned word access or a read/write conflict is rejected without touching memory.
    assign bad_op   = ((ex_mem_read | ex_mem_write) & (ex_result[1:0] != 2'b00))
                    | (ex_mem_read & ex_mem_write);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        ld_rd_d        = ld_rd_q;
        ld_rw_d        = ld_rw_q;
        rdata_d        = rdata_q;
        wb_valid_d     = wb_valid_q;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_cout_d      = wb_cout_q;
        branch_taken_d = branch_taken_q;
        fault_d        = fault_q;
        mem_we         = 1'b0;
        if (enable) begin
            wb_valid_d     = 1'b0;
            branch_taken_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        if (bad_op) begin
                            fault_d        = 1'b1;
                            wb_valid_d     = 1'b1;
                            wb_data_d      = ex_result;
                            wb_rd_d        = ex_rd;
                            wb_reg_write_d = 1'b0;
                            wb_cout_d      = 1'b0;
                        end else if (ex_mem_read) begin
                            addr_d  = idx;
                            ld_rd_d = ex_rd;
                            ld_rw_d = ex_reg_write;
                            state_d = ST_RD_ADDR;
                        end else begin
                            wb_valid_d     = 1'b1;
                            wb_data_d      = ex_result;
                            wb_rd_d        = ex_rd;
                            wb_cout_d      = ex_cout;
                            wb_reg_write_d = ex_reg_write & ~ex_mem_write & ~ex_branch;
                            branch_taken_d = ex_branch & ex_zero;
                            mem_we         = ex_mem_write;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    rdata_d = mem[addr_q];
                    state_d = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    wb_valid_d     = 1'b1;
                    wb_data_d      = rdata_q;
                    wb_rd_d        = ld_rd_q;
                    wb_reg_write_d = ld_rw_q;
                    wb_cout_d      = 1'b0;
                    state_d        = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            ld_rd_q        <= '0;
            ld_rw_q        <= 1'b0;
            rdata_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_cout_q      <= 1'b0;
            branch_taken_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            ld_rd_q        <= ld_rd_d;
            ld_rw_q        <= ld_rw_d;
            rdata_q        <= rdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_cout_q      <= wb_cout_d;
            branch_taken_q <= branch_taken_d;
            fault_q        <= fault_d;
        end
    end

    // Data memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= ex_store_data;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_cout      = wb_cout_q;
    assign branch_taken = branch_taken_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table-driven transfers with a write-back scoreboard,
// plus hand sequences for load back-pressure, enable freeze, reset mid-load and faults.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic        ex_cout;
    logic        ex_zero;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_cout;
    logic        branch_taken;
    logic        fault;

    mem_wb_stage #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_cout(ex_cout), .ex_zero(ex_zero),
        .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_cout(wb_cout),
        .branch_taken(branch_taken), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cout, zero;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rdm, wr, br, rw;
        logic        chk;
        logic [31:0] e_data;
        logic        e_rw, e_cout, e_br, e_fault;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw, cout, br, chk;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] res, input logic cout, input logic zero,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input logic rdm, input logic wr, input logic br, input logic rw,
                                input logic chk_d, input logic [31:0] e_data, input logic e_rw,
                                input logic e_cout, input logic e_br, input logic e_fault);
        vec_t v;
        v.res = res; v.cout = cout; v.zero = zero; v.sd = sd; v.rd = rd;
        v.rdm = rdm; v.wr = wr; v.br = br; v.rw = rw; v.chk = chk_d;
        v.e_data = e_data; v.e_rw = e_rw; v.e_cout = e_cout; v.e_br = e_br; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic send(input vec_t v, input logic push);
        int n;
        exp_t e;
        @(negedge clk);
        ex_result     = v.res;
        ex_cout       = v.cout;
        ex_zero       = v.zero;
        ex_store_data = v.sd;
        ex_rd         = v.rd;
        ex_mem_read   = v.rdm;
        ex_mem_write  = v.wr;
        ex_branch     = v.br;
        ex_reg_write  = v.rw;
        ex_valid      = 1'b1;
        n = 0;
        while (!ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) chk("ready_timeout", {31'd0, ex_ready}, 32'd1);
        if (push) begin
            e.data = v.e_data; e.rd = v.rd; e.rw = v.e_rw;
            e.cout = v.e_cout; e.br = v.e_br; e.chk = v.chk;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_branch    = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {31'd0, wb_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.br});
                if (e.chk) begin
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("wb_cout", {31'd0, wb_cout}, {31'd0, e.cout});
                end
            end
        end else if (branch_taken) begin
            chk("branch_without_beat", {31'd0, branch_taken}, 32'd0);
        end
    end

    task automatic chk_all_reset(input string tag);
        chk({tag, "_ex_ready"}, {31'd0, ex_ready}, 32'd1);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wb_reg_write"}, {31'd0, wb_reg_write}, 32'd0);
        chk({tag, "_wb_cout"}, {31'd0, wb_cout}, 32'd0);
        chk({tag, "_branch_taken"}, {31'd0, branch_taken}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; enable = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_cout = 1'b0;
        ex_zero = 1'b0; ex_store_data = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_branch = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;

        //             res           co z  sd            rd  rdm wr br rw chk e_data        erw eco ebr eflt
        vecs[0]  = mk(32'h0000_0005, 1, 0, 32'h0,         3, 0, 0, 0, 1, 1, 32'h0000_0005, 1, 1, 0, 0);
        vecs[1]  = mk(32'hFFFF_FFFF, 0, 0, 32'h0,        31, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 1, 0, 0, 0);
        vecs[2]  = mk(32'h0000_0000, 1, 1, 32'h0,         7, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 1, 0, 0);
        vecs[3]  = mk(32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 0);
        vecs[4]  = mk(32'h0000_0010, 1, 0, 32'h0,         8, 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
        vecs[5]  = mk(32'h0000_0104, 0, 0, 32'h1234_5678, 0, 0, 1, 0, 1, 0, 32'h0,         0, 0, 0, 0);
        vecs[6]  = mk(32'h0000_0004, 0, 0, 32'h0,         9, 1, 0, 0, 1, 1, 32'h1234_5678, 1, 0, 0, 0);
        vecs[7]  = mk(32'h0000_00FC, 0, 0, 32'hA5A5_0001, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 0);
        vecs[8]  = mk(32'h0000_00FC, 0, 0, 32'h0,        10, 1, 0, 0, 1, 1, 32'hA5A5_0001, 1, 0, 0, 0);
        vecs[9]  = mk(32'h0000_0000, 0, 1, 32'h0,         1, 0, 0, 1, 1, 0, 32'h0,         0, 0, 1, 0);
        vecs[10] = mk(32'h0000_0004, 0, 0, 32'h0,         1, 0, 0, 1, 1, 0, 32'h0,         0, 0, 0, 0);
        vecs[11] = mk(32'h0000_0020, 0, 0, 32'h1111_2222, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 0);
        vecs[12] = mk(32'h0000_0013, 0, 0, 32'h0,         4, 1, 0, 0, 1, 0, 32'h0,         0, 0, 0, 1);
        vecs[13] = mk(32'h0000_0077, 0, 0, 32'h0,         2, 0, 0, 0, 1, 1, 32'h0000_0077, 1, 0, 0, 1);

        #7;
        chk_all_reset("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i], 1'b1);
            chk("fault_after_xfer", {31'd0, fault}, {31'd0, vecs[i].e_fault});
        end
        // Misaligned load must not start the read sequence.
        chk("fault_load_ready", {31'd0, ex_ready}, 32'd1);

        // Store/load back-to-back with ex_ready observed through the load.
        send(mk(32'h30, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1), 1'b1);
        send(mk(32'h30, 0, 0, 32'h0, 8, 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 1), 1'b1);
        chk("load_ready_c1", {31'd0, ex_ready}, 32'd0);
        @(posedge clk); #1;
        chk("load_ready_c2", {31'd0, ex_ready}, 32'd0);
        @(posedge clk); #1;
        chk("load_ready_c3", {31'd0, ex_ready}, 32'd1);
        chk("load_beat_c3", {31'd0, wb_valid}, 32'd1);
        chk("fault_sticky", {31'd0, fault}, 32'd1);

        // enable=0 with a pending store: nothing may change.
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        ex_result = 32'h20; ex_store_data = 32'hBAD0_BAD0; ex_mem_write = 1'b1;
        ex_reg_write = 1'b1; ex_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("frozen_wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("frozen_ex_ready", {31'd0, ex_ready}, 32'd1);
        end
        enable = 1'b1; ex_valid = 1'b0; ex_mem_write = 1'b0;
        send(mk(32'h20, 0, 0, 32'h0, 5, 1, 0, 0, 1, 1, 32'h1111_2222, 1, 0, 0, 1), 1'b1);
        repeat (4) @(negedge clk);

        // Reset while in RD_ADDR aborts the load.
        send(mk(32'h10, 0, 0, 32'h0, 6, 1, 0, 0, 1, 1, 32'h0, 1, 0, 0, 1), 1'b0);
        chk("pre_reset_busy", {31'd0, ex_ready}, 32'd0);
        rst = 1'b1;
        #8;
        rst = 1'b0;
        chk_all_reset("midload_rst");
        repeat (4) @(negedge clk);
        chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Conflict and misaligned store: fault, no memory write.
        send(mk(32'h30, 0, 0, 32'h0, 2, 1, 1, 0, 1, 0, 32'h0, 0, 0, 0, 1), 1'b1);
        chk("conflict_fault", {31'd0, fault}, 32'd1);
        chk("conflict_ready", {31'd0, ex_ready}, 32'd1);
        send(mk(32'h32, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1), 1'b1);
        send(mk(32'h30, 1, 0, 32'h0, 12, 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 1), 1'b1);

        for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
